lieat_axi_arbiter: RTL

- Registered, single-outstanding AXI4 master-port arbiter shared by the icache (read-only) and the dcache (read and write).
- Grants one transaction at a time, latches the request, drives io_master_* from registers, and routes the response back to the owner.
- Replaces pure combinational muxing so that AR/AW payloads stay stable until accepted and R/B beats cannot be misrouted.

---
 rtl/lieat_axi_arbiter.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lieat_axi_arbiter.sv
// Single-outstanding AXI4 master-port arbiter for icache (read) and dcache (read/write).
// Ports: clock/reset, icache_axi_* (AR/R), dcache_axi_* (AR/R/AW/W/B), io_master_* (AXI4 master).
module lieat_axi_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clock,
  input  logic            reset,

  input  logic            icache_axi_arvalid,
  output logic            icache_axi_arready,
  input  logic [XLEN-1:0] icache_axi_araddr,
  output logic            icache_axi_rvalid,
  input  logic            icache_axi_rready,
  output logic [XLEN-1:0] icache_axi_rdata,

  input  logic            dcache_axi_arvalid,
  output logic            dcache_axi_arready,
  input  logic [XLEN-1:0] dcache_axi_araddr,
  input  logic [2:0]      dcache_axi_arsize,
  output logic            dcache_axi_rvalid,
  input  logic            dcache_axi_rready,
  output logic [XLEN-1:0] dcache_axi_rdata,
  input  logic            dcache_axi_awvalid,
  output logic            dcache_axi_awready,
  input  logic [XLEN-1:0] dcache_axi_awaddr,
  input  logic [2:0]      dcache_axi_awsize,
  input  logic            dcache_axi_wvalid,
  output logic            dcache_axi_wready,
  input  logic [XLEN-1:0] dcache_axi_wdata,
  output logic            dcache_axi_bvalid,
  input  logic            dcache_axi_bready,
  output logic [1:0]      dcache_axi_bresp,

  output logic            io_master_awvalid,
  input  logic            io_master_awready,
  output logic [31:0]     io_master_awaddr,
  output logic [3:0]      io_master_awid,
  output logic [7:0]      io_master_awlen,
  output logic [2:0]      io_master_awsize,
  output logic [1:0]      io_master_awburst,
  output logic            io_master_wvalid,
  input  logic            io_master_wready,
  output logic [31:0]     io_master_wdata,
  output logic [3:0]      io_master_wstrb,
  output logic            io_master_wlast,
  input  logic            io_master_bvalid,
  output logic            io_master_bready,
  input  logic [1:0]      io_master_bresp,
  input  logic [3:0]      io_master_bid,
  output logic            io_master_arvalid,
  input  logic            io_master_arready,
  output logic [31:0]     io_master_araddr,
  output logic [3:0]      io_master_arid,
  output logic [7:0]      io_master_arlen,
  output logic [2:0]      io_master_arsize,
  output logic [1:0]      io_master_arburst,
  input  logic            io_master_rvalid,
  output logic            io_master_rready,
  input  logic [31:0]     io_master_rdata,
  input  logic [1:0]      io_master_rresp,
  input  logic            io_master_rlast,
  input  logic [3:0]      io_master_rid
);

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WRESP
  } state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic            owner_ic;
  logic [XLEN-1:0] ar_addr_q;
  logic [2:0]      ar_size_q;
  logic            arvalid_q;
  logic [XLEN-1:0] aw_addr_q;
  logic [2:0]      aw_size_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      wstrb_q;
  logic            awvalid_q;
  logic            wvalid_q;
  logic            aw_done;
  logic            w_done;

  logic idle;
  logic wr_req;
  logic dr_req;
  logic ir_req;
  logic starved;
  logic grant_ic;
  logic grant_wr;
  logic grant_dr;
  logic aw_hs;
  logic w_hs;

  // rid/rresp/bid carry nothing useful with one transaction in flight
  logic unused_ok;
  assign unused_ok = ^{io_master_bid, io_master_rresp, io_master_rid};

  function automatic logic [3:0] strb_of(
    input logic [2:0] sz,
    input logic [1:0] a
  );
    if (sz == 3'd0)
      return 4'b0001 << a;
    else if (sz == 3'd1)
      return 4'b0011 << {a[1], 1'b0};
    else
      return 4'b1111;
  endfunction

  // Readies are masked during reset so nothing upstream handshakes
  assign idle    = (state == IDLE) & ~reset;
  assign wr_req  = dcache_axi_awvalid & dcache_axi_wvalid;
  assign dr_req  = dcache_axi_arvalid;
  assign ir_req  = icache_axi_arvalid;
  assign starved = (starve_cnt == SMAX) & ir_req;

  assign grant_ic = idle & ir_req & (starved | (~wr_req & ~dr_req));
  assign grant_wr = idle & ~starved & wr_req;
  assign grant_dr = idle & ~starved & ~wr_req & dr_req;

  assign icache_axi_arready = grant_ic;
  assign dcache_axi_arready = grant_dr;
  assign dcache_axi_awready = grant_wr;
  assign dcache_axi_wready  = grant_wr;

  assign aw_hs = awvalid_q & io_master_awready;
  assign w_hs  = wvalid_q & io_master_wready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner_ic   <= 1'b0;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
      arvalid_q  <= 1'b0;
      aw_addr_q  <= '0;
      aw_size_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if ((grant_wr | grant_dr) & ir_req & (starve_cnt != SMAX))
            starve_cnt <= starve_cnt + 1'b1;
          if (grant_ic) begin
            starve_cnt <= '0;
            owner_ic   <= 1'b1;
            ar_addr_q  <= icache_axi_araddr;
            ar_size_q  <= 3'b010;
            arvalid_q  <= 1'b1;
            state      <= RADDR;
          end else if (grant_wr) begin
            aw_addr_q <= dcache_axi_awaddr;
            aw_size_q <= dcache_axi_awsize;
            wdata_q   <= dcache_axi_wdata;
            wstrb_q   <= strb_of(dcache_axi_awsize,
                                 dcache_axi_awaddr[1:0]);
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= WADDR;
          end else if (grant_dr) begin
            owner_ic  <= 1'b0;
            ar_addr_q <= dcache_axi_araddr;
            ar_size_q <= dcache_axi_arsize;
            arvalid_q <= 1'b1;
            state     <= RADDR;
          end
        end
        RADDR: begin
          if (io_master_arready) begin
            arvalid_q <= 1'b0;
            state     <= RDATA;
          end
        end
        RDATA: begin
          if (io_master_rvalid & io_master_rready & io_master_rlast)
            state <= IDLE;
        end
        WADDR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          // Both channels may finish in the same cycle
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WRESP;
          end
        end
        WRESP: begin
          if (io_master_bvalid & dcache_axi_bready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_master_arvalid = arvalid_q;
  assign io_master_araddr  = ar_addr_q;
  assign io_master_arsize  = ar_size_q;
  assign io_master_arid    = owner_ic ? 4'b0010 : 4'b0001;
  assign io_master_arlen   = 8'd0;
  assign io_master_arburst = 2'b01;

  logic in_rdata;
  assign in_rdata = (state == RDATA);

  assign io_master_rready = in_rdata &
    (owner_ic ? icache_axi_rready : dcache_axi_rready);

  assign icache_axi_rvalid = in_rdata & owner_ic & io_master_rvalid;
  assign dcache_axi_rvalid = in_rdata & ~owner_ic & io_master_rvalid;
  assign icache_axi_rdata  = (in_rdata & owner_ic) ?
                             io_master_rdata : '0;
  assign dcache_axi_rdata  = (in_rdata & ~owner_ic) ?
                             io_master_rdata : '0;

  assign io_master_awvalid = awvalid_q;
  assign io_master_awaddr  = aw_addr_q;
  assign io_master_awsize  = aw_size_q;
  assign io_master_awid    = 4'b0001;
  assign io_master_awlen   = 8'd0;
  assign io_master_awburst = 2'b01;
  assign io_master_wvalid  = wvalid_q;
  assign io_master_wdata   = wdata_q;
  assign io_master_wstrb   = wstrb_q;
  assign io_master_wlast   = 1'b1;

  logic in_wresp;
  assign in_wresp = (state == WRESP);

  assign dcache_axi_bvalid = in_wresp & io_master_bvalid;
  assign dcache_axi_bresp  = in_wresp ? io_master_bresp : 2'b00;
  assign io_master_bready  = in_wresp & dcache_axi_bready;

endmodule
